cell_arbiter: RTL and testbench
===============================

CELL_ARBITER -- requirements
Module: cell_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the cell datapath (2..8).
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum consecutive cycles one grant may be held (1..255).
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-high.
REQ-005 Port req, input, N_REQ: per-requester request, level-sensitive.
REQ-006 Port done, input, N_REQ: per-requester release strobe; SHALL be honoured only for the current holder.
REQ-007 Port din, input, N_REQ: per-requester data bit offered to the shared cell.
REQ-008 Port grant, output, N_REQ: one-hot or all-zero grant vector, registered.
REQ-009 Port busy, output, 1: high while any grant is asserted, registered.
REQ-010 Port dout, output, 1: registered data bit of the current holder; 0 when no grant.
REQ-011 Port timeout, output, 1: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 FSM states: IDLE, GRANTED, RELEASE.
REQ-013 IDLE: if any req bit set, SHALL select the first set bit searching upward (with wrap) from last+1, load holder, assert grant[holder] on the next edge, and go to GRANTED.
REQ-014 Request-to-grant latency SHALL be exactly 1 cycle from an idle arbiter.
REQ-015 GRANTED: grant SHALL stay constant; hold counter SHALL increment by 1 per cycle, starting at 1 in the first granted cycle.
REQ-016 GRANTED exits to RELEASE on done[holder]=1, req[holder]=0, or counter==TIMEOUT; grant SHALL be deasserted on that edge.
REQ-017 Timeout and done/req-drop in the same cycle: release SHALL count as normal; timeout SHALL NOT pulse.
REQ-018 Timeout-only exit: timeout SHALL be 1 for exactly the RELEASE cycle.
REQ-019 RELEASE: grant all-zero for exactly one cycle; last SHALL be updated to holder; next state IDLE.
REQ-020 Grants SHALL never overlap; at least one all-zero cycle SHALL separate consecutive grants.
REQ-021 done bits of non-holders and req changes of non-holders during GRANTED SHALL be ignored.
REQ-022 dout SHALL be din[holder] sampled each GRANTED cycle (1-cycle latency), 0 in IDLE and RELEASE.
REQ-023 busy SHALL equal OR of grant.
REQ-024 Round-robin fairness: with all req held high, each requester SHALL be granted once per N_REQ grants.

Reset
REQ-025 On rst=1, outputs SHALL clear immediately: grant=0, busy=0, dout=0, timeout=0.
REQ-026 On reset: state=IDLE, counter=0, holder=0, last=N_REQ-1 (requester 0 wins first).
REQ-027 Reset asserted mid-grant SHALL drop grant without a RELEASE cycle or timeout pulse.
REQ-028 First grant after reset release SHALL follow REQ-014 timing.

Structure
REQ-029 Package cell_arb_pkg SHALL hold the state enum, state encoding constants and counter width derivation.
REQ-030 Sub-module rr_pick (combinational round-robin priority picker: req, last -> one-hot pick, valid) SHALL be instantiated once.
REQ-031 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Verification
REQ-032 Reset, then req=0001 -> grant=0001 one cycle later, busy=1; done=0001 -> grant=0000 next edge.
REQ-033 req=1111 held, each holder pulses done after 2 cycles -> grant sequence 0001,0010,0100,1000,0001 with one zero cycle between.
REQ-034 req=0100 held, no done, TIMEOUT=15 -> grant high 15 cycles, then grant=0, timeout=1 for 1 cycle; regrant of 0100 after IDLE.
REQ-035 Holder 0010, done=0010 on the cycle counter==TIMEOUT -> release, timeout stays 0.
REQ-036 Holder 0001 with din[0] toggling 1,0,1 -> dout 1,0,1 delayed one cycle; done=1000 from a non-holder ignored.
REQ-037 rst pulsed while grant=0100 -> grant, busy, dout drop asynchronously; next req=1111 grants 0001.

Source files
------------

// File: rtl/cell_arb_pkg.sv
// cell_arb_pkg -- shared definitions for the cell arbiter.
//   * FSM state encoding constants and the state enum
//   * width helpers for the hold counter and requester index
package cell_arb_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'b00;
  localparam logic [1:0] ST_GRANTED_ENC = 2'b01;
  localparam logic [1:0] ST_RELEASE_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE_ENC,
    GRANTED = ST_GRANTED_ENC,
    RELEASE = ST_RELEASE_ENC
  } arb_state_e;

  // Hold counter must reach TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cell_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin priority picker.
// Ports:
//   req   : request vector (N_REQ bits)
//   last  : index of the most recently served requester
//   pick  : one-hot winner, first set bit searching upward from last+1 with wrap
//   valid : high when any request is set
module rr_pick
  import cell_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [IDX_W-1:0] idx_s;

  // Scan requesters in rotated order starting just above last; first hit wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx_s = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_s = IDX_W'((int'(last) + i) % N_REQ);
      if (!valid && req[idx_s]) begin
        pick[idx_s] = 1'b1;
        valid       = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/cell_arbiter.sv
// cell_arbiter -- round-robin arbiter granting one requester at a time
// access to a shared single-bit cell datapath, with a hold timeout.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   req      : per-requester level request
//   done     : per-requester release strobe (only the holder's bit matters)
//   din      : per-requester data bit offered to the cell
//   grant    : registered one-hot / all-zero grant vector
//   busy     : registered OR of grant
//   dout     : registered data bit of the holder, 0 when not granted
//   timeout  : one-cycle pulse in the RELEASE cycle after a timeout revoke
module cell_arbiter
  import cell_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             dout,
  output logic             timeout
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_state_e       state_r, state_s;
  logic [IDX_W-1:0] holder_r, holder_s;
  logic [IDX_W-1:0] last_r, last_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic             busy_r, busy_s;
  logic             dout_r, dout_s;
  logic             timeout_r, timeout_s;

  logic [N_REQ-1:0] pick_s;
  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             holder_rel_s;
  logic             hold_exp_s;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (req),
    .last  (last_r),
    .pick  (pick_s),
    .valid (pick_valid_s)
  );

  // Convert the one-hot pick into a holder index.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_idx_s = pick_s[i] ? IDX_W'(i) : pick_idx_s;
    end
  end

  // Holder-only release conditions; other requesters' done/req are ignored.
  assign holder_rel_s = done[holder_r] | ~req[holder_r];
  assign hold_exp_s   = (count_r == CNT_W'(TIMEOUT));

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s   = state_r;
    holder_s  = holder_r;
    last_s    = last_r;
    count_s   = count_r;
    grant_s   = grant_r;
    dout_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s  = GRANTED;
          holder_s = pick_idx_s;
          grant_s  = pick_s;
          count_s  = CNT_W'(1);
        end else begin
          grant_s  = '0;
          count_s  = '0;
        end
      end
      GRANTED: begin
        if (holder_rel_s || hold_exp_s) begin
          state_s   = RELEASE;
          grant_s   = '0;
          // A normal release in the same cycle as expiry masks the pulse.
          timeout_s = hold_exp_s & ~holder_rel_s;
        end else begin
          count_s   = count_r + CNT_W'(1);
          dout_s    = din[holder_r];
        end
      end
      RELEASE: begin
        state_s = IDLE;
        last_s  = holder_r;
        count_s = '0;
        grant_s = '0;
      end
      default: begin
        state_s = IDLE;
        count_s = '0;
        grant_s = '0;
      end
    endcase
    busy_s = |grant_s;
  end

  // State and output registers; reset clears outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      holder_r  <= '0;
      last_r    <= IDX_W'(N_REQ - 1);
      count_r   <= '0;
      grant_r   <= '0;
      busy_r    <= 1'b0;
      dout_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      holder_r  <= holder_s;
      last_r    <= last_s;
      count_r   <= count_s;
      grant_r   <= grant_s;
      busy_r    <= busy_s;
      dout_r    <= dout_s;
      timeout_r <= timeout_s;
    end
  end

  assign grant   = grant_r;
  assign busy    = busy_r;
  assign dout    = dout_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_cell_arbiter.sv
// tb_cell_arbiter -- directed self-checking bench for cell_arbiter
// (N_REQ=4, TIMEOUT=15).
module tb_cell_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] din;
  logic [3:0] grant;
  logic       busy;
  logic       dout;
  logic       timeout;

  int n_checks;
  int n_errors;

  cell_arbiter #(.N_REQ(4), .TIMEOUT(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .din     (din),
    .grant   (grant),
    .busy    (busy),
    .dout    (dout),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    din  = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (grant != 4'b0000) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  logic [3:0] seq [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;

    // Reset state
    rst = 1'b1; req = 4'b0000; done = 4'b0000; din = 4'b0000;
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Single request, one-cycle latency, done release
    req = 4'b0001;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_hold", 32'(grant), 32'h1);
    done = 4'b0001;
    tick();
    chk("t1_rel_grant", 32'(grant), 32'h0);
    chk("t1_rel_busy", 32'(busy), 32'd0);
    chk("t1_rel_to", 32'(timeout), 32'd0);
    done = 4'b0000; req = 4'b0000;
    tick();

    // Round-robin with all requesting
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t2_wait");
      chk("t2_grant", 32'(grant), 32'(seq[k]));
      tick();
      chk("t2_hold", 32'(grant), 32'(seq[k]));
      done = seq[k];
      tick();
      chk("t2_gap", 32'(grant), 32'h0);
      done = 4'b0000;
    end

    // Timeout-only revoke
    do_reset();
    req = 4'b0100;
    tick();
    chk("t3_grant", 32'(grant), 32'h4);
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk("t3_hold", 32'(grant), 32'h4);
    end
    tick();
    chk("t3_rev_grant", 32'(grant), 32'h0);
    chk("t3_rev_to", 32'(timeout), 32'd1);
    tick();
    chk("t3_idle_to", 32'(timeout), 32'd0);
    chk("t3_idle_grant", 32'(grant), 32'h0);
    tick();
    chk("t3_regrant", 32'(grant), 32'h4);

    // done on the expiry cycle: normal release, no pulse
    do_reset();
    req = 4'b0010;
    tick();
    chk("t4_grant", 32'(grant), 32'h2);
    for (int i = 2; i <= 15; i++) tick();
    chk("t4_hold15", 32'(grant), 32'h2);
    done = 4'b0010;
    tick();
    chk("t4_rel_grant", 32'(grant), 32'h0);
    chk("t4_rel_to", 32'(timeout), 32'd0);
    done = 4'b0000; req = 4'b0000;

    // dout follows din[holder] one cycle late; non-holder done ignored
    do_reset();
    req = 4'b0001;
    tick();
    chk("t5_grant", 32'(grant), 32'h1);
    chk("t5_dout0", 32'(dout), 32'd0);
    din = 4'b0001; done = 4'b1000;
    tick();
    chk("t5_dout_a", 32'(dout), 32'd1);
    chk("t5_ignore", 32'(grant), 32'h1);
    din = 4'b1110;
    tick();
    chk("t5_dout_b", 32'(dout), 32'd0);
    din = 4'b0001;
    tick();
    chk("t5_dout_c", 32'(dout), 32'd1);
    chk("t5_ignore2", 32'(grant), 32'h1);
    done = 4'b0001;
    tick();
    chk("t5_rel_grant", 32'(grant), 32'h0);
    chk("t5_rel_dout", 32'(dout), 32'd0);
    done = 4'b0000; din = 4'b0000;

    // Holder dropping req releases; the other requester follows
    do_reset();
    req = 4'b0011;
    tick();
    chk("t7_grant", 32'(grant), 32'h1);
    req = 4'b0010;
    tick();
    chk("t7_drop", 32'(grant), 32'h0);
    chk("t7_drop_to", 32'(timeout), 32'd0);
    wait_grant("t7_wait");
    chk("t7_next", 32'(grant), 32'h2);

    // Asynchronous reset mid-grant
    do_reset();
    req = 4'b0100;
    tick();
    chk("t6_grant", 32'(grant), 32'h4);
    din = 4'b0100;
    tick();
    chk("t6_dout", 32'(dout), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_grant", 32'(grant), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_dout", 32'(dout), 32'd0);
    chk("t6_async_to", 32'(timeout), 32'd0);
    tick();
    rst = 1'b0; req = 4'b1111; din = 4'b0000;
    tick();
    chk("t6_after", 32'(grant), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
